mips_multicycle_sequencer: RTL and testbench

Multi-cycle control sequencer for the MIPS datapath. It replaces single-cycle control with an FSM that shares one memory port between instruction fetch and data access. It steps each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the datapath strobes (IR, PC, register file, Z/C flags, hardware stack). It sits between the instruction decoder, which supplies op_class, and the DataPath. It also detects memory timeouts and stack overflow on call.

---
 rtl/mips_seq_pkg.sv | 34 +++
 rtl/mips_mem_wait_timer.sv | 32 +++
 rtl/mips_multicycle_sequencer.sv | 154 +++++++++++++++
 tb/tb_mips_multicycle_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_seq_pkg.sv
// Shared encodings for the multi-cycle MIPS control sequencer: FSM states,
// decoded instruction classes and PC source selects.
package mips_seq_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_EXEC   = 3'd3,
      S_MEM    = 3'd4,
      S_WB     = 3'd5,
      S_UNUSED = 3'd6,
      S_FAULT  = 3'd7
   } state_e;

   typedef enum logic [2:0] {
      OP_ALU_R  = 3'd0,
      OP_ALU_I  = 3'd1,
      OP_LOAD   = 3'd2,
      OP_STORE  = 3'd3,
      OP_BRANCH = 3'd4,
      OP_JUMP   = 3'd5,
      OP_CALL   = 3'd6,
      OP_RET    = 3'd7
   } op_class_e;

   typedef enum logic [1:0] {
      PC_INC = 2'd0,
      PC_BR  = 2'd1,
      PC_JMP = 2'd2,
      PC_STK = 2'd3
   } pc_src_e;

endpackage

// File: rtl/mips_mem_wait_timer.sv
// Counts consecutive memory wait cycles; timeout flags the last permitted
// wait cycle so the sequencer can abandon the access on that edge.
module mips_mem_wait_timer #(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clear,
   input  logic enable,
   output logic timeout
);

   localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;

   // NOTE: sequential state is written with non-blocking assignments so every
   // register samples its inputs from the same edge, regardless of block order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (enable) begin
         cnt <= cnt + CNT_W'(1);
      end
   end

   assign timeout = (cnt == LAST_WAIT);

endmodule

// File: rtl/mips_multicycle_sequencer.sv
// Multi-cycle MIPS control FSM sharing one memory port between fetch and data
// access; drives datapath strobes and traps on memory timeout or stack overflow.
module mips_multicycle_sequencer
   import mips_seq_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 16,
   parameter int CNT_W          = 5
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       run,
   input  logic [2:0] op_class,
   input  logic       branch_taken,
   input  logic       stack_overflow,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_we,
   output logic       fetch_sel,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       reg_write,
   output logic       mem_or_alu,
   output logic       update_z_c,
   output logic       stack_push,
   output logic       stack_pop,
   output logic       busy,
   output logic       fault,
   output logic [2:0] state
);

   state_e    state_q;
   state_e    next_instr;
   op_class_e op;
   pc_src_e   pc_sel;
   logic      waiting;
   logic      timed_out;

   assign op         = op_class_e'(op_class);
   assign next_instr = run ? S_FETCH : S_IDLE;

   // The counter only advances while a memory access is stalled; any other
   // cycle (including completion) leaves it at zero for the next access.
   assign waiting = ((state_q == S_FETCH) || (state_q == S_MEM)) && !mem_ready;

   mips_mem_wait_timer #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_W          (CNT_W)
   ) u_wait_timer (
      .clk     (clk),
      .rst_n   (rst),
      .clear   (!waiting),
      .enable  (waiting),
      .timeout (timed_out)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:   if (run) state_q <= S_FETCH;
            S_FETCH: begin
               if (mem_ready)      state_q <= S_DECODE;
               else if (timed_out) state_q <= S_FAULT;
            end
            S_DECODE: state_q <= S_EXEC;
            S_EXEC: begin
               case (op)
                  OP_ALU_R, OP_ALU_I: state_q <= S_WB;
                  OP_LOAD, OP_STORE:  state_q <= S_MEM;
                  OP_CALL:            state_q <= stack_overflow ? S_FAULT : next_instr;
                  default:            state_q <= next_instr;
               endcase
            end
            S_MEM: begin
               if (mem_ready)      state_q <= (op == OP_LOAD) ? S_WB : next_instr;
               else if (timed_out) state_q <= S_FAULT;
            end
            S_WB:     state_q <= next_instr;
            S_FAULT:  state_q <= S_FAULT;
            default:  state_q <= S_IDLE;
         endcase
      end
   end

   // NOTE: every output gets a default before the case so no path through the
   // block leaves a signal unassigned, which would otherwise infer a latch.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      fetch_sel  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_sel     = PC_INC;
      reg_write  = 1'b0;
      mem_or_alu = 1'b0;
      update_z_c = 1'b0;
      stack_push = 1'b0;
      stack_pop  = 1'b0;
      case (state_q)
         S_FETCH: begin
            mem_req   = 1'b1;
            fetch_sel = 1'b1;
            if (mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
            end
         end
         S_EXEC: begin
            case (op)
               OP_ALU_R, OP_ALU_I: update_z_c = 1'b1;
               OP_BRANCH: begin
                  pc_write = branch_taken;
                  pc_sel   = PC_BR;
               end
               OP_JUMP: begin
                  pc_write = 1'b1;
                  pc_sel   = PC_JMP;
               end
               OP_CALL: begin
                  // An overflowing call must not disturb the stack or the PC.
                  if (!stack_overflow) begin
                     stack_push = 1'b1;
                     pc_write   = 1'b1;
                     pc_sel     = PC_JMP;
                  end
               end
               OP_RET: begin
                  stack_pop = 1'b1;
                  pc_write  = 1'b1;
                  pc_sel    = PC_STK;
               end
               default: ;
            endcase
         end
         S_MEM: begin
            mem_req = 1'b1;
            mem_we  = (op == OP_STORE);
         end
         S_WB: begin
            reg_write  = 1'b1;
            mem_or_alu = (op == OP_LOAD);
         end
         default: ;
      endcase
   end

   assign pc_src = pc_sel;
   assign busy   = (state_q != S_IDLE) && (state_q != S_FAULT);
   assign fault  = (state_q == S_FAULT);
   assign state  = state_q;

endmodule

// File: tb/tb_mips_multicycle_sequencer.sv
// Self-checking bench: each instruction is replayed from a per-class cycle
// script and every cycle's outputs are compared to the expected strobe set.
module tb_mips_multicycle_sequencer;

   localparam int TO = 16;

   localparam logic [2:0] ST_IDLE = 3'd0, ST_FETCH = 3'd1, ST_DECODE = 3'd2,
                          ST_EXEC = 3'd3, ST_MEM = 3'd4, ST_WB = 3'd5, ST_FAULT = 3'd7;
   localparam logic [2:0] OP_ALU_R = 3'd0, OP_ALU_I = 3'd1, OP_LOAD = 3'd2, OP_STORE = 3'd3,
                          OP_BRANCH = 3'd4, OP_JUMP = 3'd5, OP_CALL = 3'd6, OP_RET = 3'd7;
   localparam int O_FETCH = 0, O_IDLE = 1, O_FAULT = 2;

   typedef struct packed {
      logic [2:0] st;
      logic       mem_req, mem_we, fetch_sel, ir_write, pc_write;
      logic [1:0] pc_src;
      logic       reg_write, mem_or_alu, update_z_c, stack_push, stack_pop, busy, fault;
   } obs_t;

   logic       clk = 1'b0, rst = 1'b0, run = 1'b0;
   logic [2:0] op_class = 3'd0;
   logic       branch_taken = 1'b0, stack_overflow = 1'b0, mem_ready = 1'b0;
   logic       mem_req, mem_we, fetch_sel, ir_write, pc_write;
   logic [1:0] pc_src;
   logic       reg_write, mem_or_alu, update_z_c, stack_push, stack_pop, busy, fault;
   logic [2:0] state;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mips_multicycle_sequencer #(.TIMEOUT_CYCLES(TO), .CNT_W(5)) dut (
      .clk(clk), .rst(rst), .run(run), .op_class(op_class),
      .branch_taken(branch_taken), .stack_overflow(stack_overflow), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_we(mem_we), .fetch_sel(fetch_sel), .ir_write(ir_write),
      .pc_write(pc_write), .pc_src(pc_src), .reg_write(reg_write), .mem_or_alu(mem_or_alu),
      .update_z_c(update_z_c), .stack_push(stack_push), .stack_pop(stack_pop),
      .busy(busy), .fault(fault), .state(state)
   );

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic obs_t base(input logic [2:0] st);
      obs_t e;
      e       = '0;
      e.st    = st;
      e.busy  = (st != ST_IDLE) && (st != ST_FAULT);
      e.fault = (st == ST_FAULT);
      return e;
   endfunction

   // Inputs are driven at posedge+1; outputs are sampled 2 ns later.
   task automatic chk(input string tag, input obs_t e);
      obs_t o;
      #2;
      o = {state, mem_req, mem_we, fetch_sel, ir_write, pc_write, pc_src,
           reg_write, mem_or_alu, update_z_c, stack_push, stack_pop, busy, fault};
      checks++;
      assert (o === e) else begin
         errors++;
         $error("FAIL %s observed=%b expected=%b", tag, o, e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic noise();
      mem_ready      = 1'($urandom);
      run            = 1'($urandom);
      branch_taken   = 1'($urandom);
      stack_overflow = 1'($urandom);
   endtask

   // Async reset pulse; on return the sequencer is one edge into FETCH.
   task automatic do_reset();
      rst = 1'b0;
      chk("rst_async", base(ST_IDLE));
      tick();
      noise();
      chk("rst_held", base(ST_IDLE));
      tick();
      noise();
      rst = 1'b1;
      run = 1'b1;
      chk("rst_release", base(ST_IDLE));
      tick();
   endtask

   task automatic do_idle();
      for (int i = 0; i < 8; i++) begin
         noise();
         if (i >= 3) run = 1'b1;
         chk("idle", base(ST_IDLE));
         tick();
         if (run) break;
      end
   endtask

   task automatic instr(input logic [2:0] op, input int fw, input int mw, input bit taken,
                        input bit ovf, input int fin_run, output int outcome);
      obs_t e;
      bit   r;
      r       = (fin_run == 2) ? 1'($urandom) : (fin_run != 0);
      outcome = r ? O_FETCH : O_IDLE;
      for (int i = 0; i < fw && i < TO; i++) begin
         noise(); mem_ready = 1'b0; op_class = 3'($urandom);
         e = base(ST_FETCH); e.mem_req = 1; e.fetch_sel = 1;
         chk("fetch_wait", e); tick();
      end
      if (fw >= TO) begin
         outcome = O_FAULT;
         return;
      end
      noise(); mem_ready = 1'b1; op_class = 3'($urandom);
      e = base(ST_FETCH); e.mem_req = 1; e.fetch_sel = 1; e.ir_write = 1; e.pc_write = 1; e.pc_src = 2'd0;
      chk("fetch_done", e); tick();
      noise(); op_class = op;
      chk("decode", base(ST_DECODE)); tick();
      noise();
      e = base(ST_EXEC);
      case (op)
         OP_ALU_R, OP_ALU_I: begin
            e.update_z_c = 1; chk("exec_alu", e); tick();
            noise(); run = r;
            e = base(ST_WB); e.reg_write = 1; chk("wb_alu", e); tick();
         end
         OP_LOAD, OP_STORE: begin
            chk("exec_ldst", e); tick();
            for (int i = 0; i < mw && i < TO; i++) begin
               noise(); mem_ready = 1'b0;
               e = base(ST_MEM); e.mem_req = 1; e.mem_we = (op == OP_STORE);
               chk("mem_wait", e); tick();
            end
            if (mw >= TO) begin
               outcome = O_FAULT;
               return;
            end
            noise(); mem_ready = 1'b1;
            if (op == OP_STORE) run = r;
            e = base(ST_MEM); e.mem_req = 1; e.mem_we = (op == OP_STORE);
            chk("mem_done", e); tick();
            if (op == OP_LOAD) begin
               noise(); run = r;
               e = base(ST_WB); e.reg_write = 1; e.mem_or_alu = 1;
               chk("wb_load", e); tick();
            end
         end
         OP_BRANCH: begin
            branch_taken = taken; run = r;
            e.pc_write = taken; e.pc_src = 2'd1;
            chk("exec_branch", e); tick();
         end
         OP_JUMP: begin
            run = r; e.pc_write = 1; e.pc_src = 2'd2;
            chk("exec_jump", e); tick();
         end
         OP_CALL: begin
            stack_overflow = ovf; run = r;
            if (ovf) begin
               chk("exec_call_ovf", e); tick();
               outcome = O_FAULT;
            end else begin
               e.stack_push = 1; e.pc_write = 1; e.pc_src = 2'd2;
               chk("exec_call", e); tick();
            end
         end
         default: begin
            run = r; e.stack_pop = 1; e.pc_write = 1; e.pc_src = 2'd3;
            chk("exec_ret", e); tick();
         end
      endcase
   endtask

   // Runs one instruction plus whatever follows it; always leaves the DUT in FETCH.
   task automatic go(input logic [2:0] op, input int fw, input int mw, input bit taken,
                     input bit ovf, input int fin_run, input int hold);
      int oc;
      instr(op, fw, mw, taken, ovf, fin_run, oc);
      if (oc == O_IDLE) begin
         do_idle();
      end else if (oc == O_FAULT) begin
         for (int i = 0; i < hold; i++) begin
            noise(); op_class = 3'($urandom);
            chk("fault_hold", base(ST_FAULT)); tick();
         end
         do_reset();
      end
   endtask

   initial begin
      obs_t e;
      #1;
      chk("reset_state", base(ST_IDLE));
      tick();
      rst = 1'b1; run = 1'b1;
      chk("first_idle", base(ST_IDLE));
      tick();

      go(OP_ALU_R,  0, 0, 0, 0, 1, 0);
      go(OP_ALU_I,  2, 0, 0, 0, 1, 0);
      go(OP_LOAD,   0, 3, 0, 0, 1, 0);
      go(OP_STORE,  0, 3, 0, 0, 1, 0);
      go(OP_CALL,   0, 0, 0, 0, 1, 0);
      go(OP_RET,    0, 0, 0, 0, 1, 0);
      go(OP_JUMP,   1, 0, 0, 0, 1, 0);
      go(OP_BRANCH, 0, 0, 0, 0, 1, 0);
      go(OP_BRANCH, 0, 0, 1, 0, 1, 0);
      go(OP_BRANCH, 0, 0, 1, 0, 0, 0);

      // Reset asserted while FETCH is requesting memory.
      noise(); mem_ready = 1'b0;
      e = base(ST_FETCH); e.mem_req = 1; e.fetch_sel = 1;
      chk("pre_reset_fetch", e);
      do_reset();

      go(OP_CALL,  0, 0, 0, 1, 1, 50);
      go(OP_ALU_R, 16, 0, 0, 0, 1, 3);
      go(OP_ALU_R, 15, 0, 0, 0, 1, 0);
      go(OP_LOAD,  0, 16, 0, 0, 1, 3);
      go(OP_STORE, 0, 15, 0, 0, 1, 0);

      for (int n = 0; n < 150; n++) begin
         logic [2:0] op;
         int fw, mw;
         op = 3'($urandom);
         fw = ($urandom_range(0, 19) == 0) ? (15 + int'($urandom_range(0, 1))) : int'($urandom_range(0, 3));
         mw = ($urandom_range(0, 19) == 0) ? (15 + int'($urandom_range(0, 1))) : int'($urandom_range(0, 3));
         go(op, fw, mw, 1'($urandom), ($urandom_range(0, 7) == 0), 2, 5);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
